// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path.
// Contents: opcodes, 4-bit state codes, ALU/mux select encodings, the packed
// control word passed from the output decoder to the top, and an opcode
// legality helper used by the decoder.
package multicycle_control_pkg;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    // alu_op to alu_control
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // PC input select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_mc_output_decode.sv
// Combinational control-word decoder for the multicycle control FSM.
// Ports:
//   i_state     - current FSM state
//   i_mem_ready - memory handshake (FETCH/MEM_WRITE use it Mealy-style)
//   i_instr_op  - IR opcode, used in DECODE to flag unsupported opcodes
//   o_ctrl      - full control word; every field is 0 unless set below
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic [5:0] i_instr_op,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                // PC+4 computed in parallel with the instruction read; IR and
                // PC only commit on the cycle memory actually returns data.
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                o_ctrl.alu_src_b = SRCB_IMM_SL2;
                o_ctrl.alu_op    = ALU_ADD;
                if (!is_supported_op(i_instr_op)) begin
                    o_ctrl.illegal_op = 1'b1;
                    o_ctrl.retire     = 1'b1;
                end
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.retire    = i_mem_ready;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.retire    = 1'b1;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.retire    = 1'b1;
            end
            default: ; // RESET and unused codes drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// retired-instruction counter. The control word itself comes from
// mc_output_decode.
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   instr_op        - IR opcode (valid from DECODE onward)
//   mem_ready       - memory completes current access this cycle
//   pc_write .. pc_source - datapath enables and mux selects
//   state_out       - current state code (debug)
//   retire          - pulse in the last cycle of each instruction
//   illegal_op      - pulse in DECODE for an unsupported opcode
//   instr_count     - retired-instruction count, wraps
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           instr_op,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state_out,
    output logic                 retire,
    output logic                 illegal_op,
    output logic [WORD_SIZE-1:0] instr_count
);

    state_t               r_state;
    state_t               w_next_state;
    ctrl_t                w_ctrl;
    logic [WORD_SIZE-1:0] r_instr_count;

    // Reset drops the state straight to RESET, whose control word is all
    // zero, so an in-flight instruction is abandoned with no write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_RESET;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_RESET:     w_next_state = S_FETCH;
            S_FETCH:     w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instr_op)
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDI_EX;
                    default:      w_next_state = S_FETCH; // illegal: NOP
                endcase
            end
            S_MEM_ADDR:  w_next_state = (instr_op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next_state = S_R_WB;
            S_ADDI_EX:   w_next_state = S_ADDI_WB;
            default:     w_next_state = S_FETCH; // writeback/branch/jump and codes 13-15
        endcase
    end

    mc_output_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .i_instr_op  (instr_op),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               r_instr_count <= '0;
        else if (w_ctrl.retire) r_instr_count <= r_instr_count + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    end

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign retire        = w_ctrl.retire;
    assign illegal_op    = w_ctrl.illegal_op;
    assign state_out     = r_state;
    assign instr_count   = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Stimulus pushes the expected
// per-cycle state/control/count and per-instruction latency; a monitor pops
// and compares at each falling edge.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  instr_op = 6'h00;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state_out;
    logic        retire, illegal_op;
    logic [31:0] instr_count;

    // Narrow-counter instance, used only for the wrap check.
    logic        rst_w = 1'b0;
    logic [5:0]  instr_op_w = 6'h02;
    logic        mem_ready_w = 1'b1;
    logic        pcw_w, pcwc_w, iord_w, mr_w, mw_w, irw_w, m2r_w, rdst_w, rw_w, asa_w;
    logic [1:0]  asb_w, aop_w, psrc_w;
    logic [3:0]  st_w;
    logic        retire_w, ill_w;
    logic [3:0]  instr_count_w;

    always #5 clk = ~clk;

    multicycle_control #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state_out(state_out), .retire(retire),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    multicycle_control #(.WORD_SIZE(4)) dut_w (
        .clk(clk), .rst(rst_w), .instr_op(instr_op_w), .mem_ready(mem_ready_w),
        .pc_write(pcw_w), .pc_write_cond(pcwc_w), .i_or_d(iord_w),
        .mem_read(mr_w), .mem_write(mw_w), .ir_write(irw_w),
        .mem_to_reg(m2r_w), .reg_dst(rdst_w), .reg_write(rw_w),
        .alu_src_a(asa_w), .alu_src_b(asb_w), .alu_op(aop_w),
        .pc_source(psrc_w), .state_out(st_w), .retire(retire_w),
        .illegal_op(ill_w), .instr_count(instr_count_w)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       illegal_op;
    } tb_ctrl_t;

    typedef struct {
        logic [3:0]  st;
        tb_ctrl_t    c;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        trace_q[$];
    int          lat_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic tb_ctrl_t act_ctrl();
        tb_ctrl_t c;
        c = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, retire, illegal_op};
        return c;
    endfunction

    // Expected control word per state, written from the state table.
    function automatic tb_ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        tb_ctrl_t c;
        c = '0;
        case (st)
            4'd1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd2:  begin
                c.alu_src_b = 2'b11;
                if (!(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08})) begin
                    c.illegal_op = 1; c.retire = 1;
                end
            end
            4'd3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd4:  begin c.mem_read = 1; c.i_or_d = 1; end
            4'd5:  begin c.reg_write = 1; c.mem_to_reg = 1; c.retire = 1; end
            4'd6:  begin c.mem_write = 1; c.i_or_d = 1; c.retire = rdy; end
            4'd7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            4'd8:  begin c.reg_write = 1; c.reg_dst = 1; c.retire = 1; end
            4'd9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; c.retire = 1; end
            4'd10: begin c.pc_write = 1; c.pc_source = 2'b10; c.retire = 1; end
            4'd11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd12: begin c.reg_write = 1; c.retire = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // One clock of stimulus: record what this cycle must look like, then advance.
    task automatic step(input logic rdy, input logic [3:0] st);
        cyc_t r;
        r.st  = st;
        r.c   = exp_ctrl(st, rdy, instr_op);
        r.cnt = exp_cnt;
        trace_q.push_back(r);
        if (r.c.retire) exp_cnt = exp_cnt + 1;
        mem_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int lat);
        instr_op = op;
        lat_q.push_back(lat);
        repeat (fw) step(1'b0, 4'd1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        case (op)
            6'h00: begin step(1'b1, 4'd7); step(1'b1, 4'd8); end
            6'h23: begin
                step(1'b1, 4'd3);
                repeat (mw) step(1'b0, 4'd4);
                step(1'b1, 4'd4);
                step(1'b1, 4'd5);
            end
            6'h2B: begin
                step(1'b1, 4'd3);
                repeat (mw) step(1'b0, 4'd6);
                step(1'b1, 4'd6);
            end
            6'h04: step(1'b1, 4'd9);
            6'h02: step(1'b1, 4'd10);
            6'h08: begin step(1'b1, 4'd11); step(1'b1, 4'd12); end
            default: ;
        endcase
    endtask

    // Monitor: per-cycle trace compare plus retire-to-retire latency.
    initial begin
        cyc_t r;
        int   cyc;
        int   l;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cyc = 0;
            end else begin
                if (trace_q.size() > 0) begin
                    r = trace_q.pop_front();
                    check("state", 64'(state_out), 64'(r.st));
                    check("ctrl", 64'(act_ctrl()), 64'(r.c));
                    check("instr_count", 64'(instr_count), 64'(r.cnt));
                end
                if (mem_read && mem_write) check("rd_wr_exclusive", 64'(1), 64'(0));
                if (state_out != 4'd0) cyc++;
                if (retire) begin
                    if (lat_q.size() == 0) begin
                        check("unexpected_retire", 64'(1), 64'(0));
                    end else begin
                        l = lat_q.pop_front();
                        check("latency", 64'(cyc), 64'(l));
                    end
                    cyc = 0;
                end
            end
        end
    end

    // Directed vectors: opcode, FETCH waits, memory waits, hand-computed latency.
    typedef struct { logic [5:0] op; int fw; int mw; int lat; } vec_t;
    vec_t vecs[9];

    initial begin
        int  nret;
        bit  done;
        vecs[0] = '{6'h00, 0, 0, 4};
        vecs[1] = '{6'h23, 0, 0, 5};
        vecs[2] = '{6'h2B, 0, 0, 4};
        vecs[3] = '{6'h04, 0, 0, 3};
        vecs[4] = '{6'h02, 0, 0, 3};
        vecs[5] = '{6'h08, 0, 0, 4};
        vecs[6] = '{6'h23, 3, 2, 10};
        vecs[7] = '{6'h2B, 0, 2, 6};
        vecs[8] = '{6'h3F, 0, 0, 2};

        #1;
        check("reset_state", 64'(state_out), 64'(0));
        check("reset_ctrl", 64'(act_ctrl()), 64'(0));
        check("reset_count", 64'(instr_count), 64'(0));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 4'd0);

        for (int i = 0; i < 6; i++) run_instr(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].lat);
        check("count_after_six", 64'(instr_count), 64'(6));
        for (int i = 6; i < 9; i++) run_instr(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].lat);
        check("count_after_nine", 64'(instr_count), 64'(9));

        // LW aborted by reset in the middle of MEM_READ.
        instr_op = 6'h23;
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        mem_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("abort_state", 64'(state_out), 64'(0));
        check("abort_ctrl", 64'(act_ctrl()), 64'(0));
        check("abort_count", 64'(instr_count), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_cnt = 0;
        step(1'b1, 4'd0);
        run_instr(6'h00, 0, 0, 4);
        mem_ready = 1'b0; // park the main instance in FETCH

        // Counter wrap on the 4-bit instance running back-to-back jumps.
        check("wrap_reset_count", 64'(instr_count_w), 64'(0));
        rst_w = 1'b1;
        nret = 0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (retire_w) begin
                nret++;
                if (nret == 16) begin
                    check("wrap_max", 64'(instr_count_w), 64'(4'hF));
                    @(negedge clk);
                    check("wrap_zero", 64'(instr_count_w), 64'(0));
                    done = 1;
                end
            end
        end
        if (!done) check("wrap_timeout", 64'(0), 64'(1));

        @(posedge clk); #1;
        check("trace_drained", 64'(trace_q.size()), 64'(0));
        check("latency_drained", 64'(lat_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multicycle MIPS datapath: one shared unified memory, IR, A/B/ALUOut/MDR registers, a single ALU reused for PC+4, branch target and execute.
- Replaces the single-cycle control_unit. Drives every mux select and register enable per state, and stalls on a memory ready handshake.
- Counts retired instructions for debug.

Parameters:
- WORD_SIZE, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_op  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle. Tie high for zero-wait memory.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (datapath ANDs with zero).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  to alu_control: 00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_out  out  4  current state encoding, for debug.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- instr_count  out  WORD_SIZE  retired-instruction count.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to RESET (0). instr_count = 0.
  - All control outputs are 0 while in RESET. RESET always goes to FETCH on the next edge.
  - Reset mid-instruction aborts immediately with no partial PC or register write.
- State encoding: RESET 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12. Codes 13-15 go to FETCH.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready (Mealy).
  - Stays in FETCH while mem_ready = 0. Goes to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXECUTE
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDI_EX
  - any other -> FETCH, with illegal_op = 1 and retire = 1 (treated as a NOP).
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready = 1, then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, retire = 1. Goes to FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Holds while mem_ready = 0. On mem_ready = 1: retire = 1, go to FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, retire = 1. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, retire = 1. Goes to FETCH.
- JUMP: pc_write = 1, pc_source = 10, retire = 1. Goes to FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, retire = 1. Goes to FETCH.
- Latency with mem_ready held high, counted FETCH through last state: R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, illegal 2. Each mem_ready = 0 cycle adds one cycle.
- Request stability: mem_read and mem_write stay constant while waiting. mem_read and mem_write are never both 1.
- Counter: instr_count increments by 1 on every edge where retire = 1. It wraps from 2^WORD_SIZE - 1 to 0.

Decomposition:
- Shared constants go in cpu_constant_library.v:
  - opcodes: R-type, LW, SW, BEQ, J, ADDI
  - the 4-bit state codes
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, mc_output_decode: combinational state + mem_ready -> control word. The top level holds only the state register, next-state logic and the counter.

Test Plan:
- Assert rst = 0 mid-MEM_READ of an LW -> state_out = 0 and all controls 0 immediately. After release: one RESET cycle, then FETCH. instr_count = 0.
- mem_ready = 1, opcodes 0x00, 0x23, 0x2B, 0x04, 0x02, 0x08 in sequence -> state trace matches Behaviour, retire spacing 4/5/4/3/3/4 cycles, instr_count = 6.
- LW with mem_ready = 0 for 3 cycles in FETCH and 2 in MEM_READ -> LW takes 10 cycles. ir_write and pc_write are 1 only in the ready cycle. mem_read is held steady through the waits.
- SW with mem_ready low for 2 cycles -> mem_write = 1 for 3 cycles, retire only on the ready cycle, reg_write never asserted.
- Opcode 0x3F -> illegal_op and retire pulse in DECODE, next state FETCH, no reg_write or mem_write.
- Force instr_count to 0xFFFFFFFF, then retire one instruction -> instr_count = 0.
